// File: rtl/stream_accumulator.sv
// Sums COUNT operands of SIZE bits per result over a valid/ready stream, flagging any carry-out.
// Optional macro STREAM_ACCUMULATOR_SATURATE_EN clamps the sum to all-ones on carry instead of wrapping.
module stream_accumulator #(
    parameter int SIZE  = 4,
    parameter int COUNT = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [SIZE-1:0] in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SIZE-1:0] out_sum,
    output logic            out_ovf
);
    localparam int CW = $clog2(COUNT + 1);

    typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

    state_t          state;
    logic [SIZE-1:0] acc;
    logic [CW-1:0]   cnt;
    logic            ovf;

    logic            accept;
    logic [SIZE:0]   sum;
    logic [SIZE-1:0] acc_add;
    logic [CW-1:0]   cnt_inc;
    logic            ovf_add;

    assign accept  = in_valid && in_ready;
    assign sum     = {1'b0, acc} + {1'b0, in_data};
    assign cnt_inc = cnt + 1'b1;
    assign ovf_add = ovf | sum[SIZE];

`ifdef STREAM_ACCUMULATOR_SATURATE_EN
    // Once saturated, acc is all-ones and any further add either carries or is zero,
    // so it stays clamped for the rest of the result.
    assign acc_add = sum[SIZE] ? {SIZE{1'b1}} : sum[SIZE-1:0];
`else
    assign acc_add = sum[SIZE-1:0];
`endif

    // All handshake outputs are registered alongside the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        acc <= in_data;
                        cnt <= CW'(1);
                        ovf <= 1'b0;
                        if (COUNT == 1) begin
                            state     <= HOLD;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                            out_sum   <= in_data;
                            out_ovf   <= 1'b0;
                        end else begin
                            state <= ACC;
                        end
                    end
                end
                ACC: begin
                    if (accept) begin
                        acc <= acc_add;
                        ovf <= ovf_add;
                        cnt <= cnt_inc;
                        if (cnt_inc == CW'(COUNT)) begin
                            state     <= HOLD;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                            out_sum   <= acc_add;
                            out_ovf   <= ovf_add;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        acc       <= '0;
                        cnt       <= '0;
                        ovf       <= 1'b0;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                        out_sum   <= '0;
                        out_ovf   <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                    out_sum   <= '0;
                    out_ovf   <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_stream_accumulator.sv
// Self-checking bench: vector table, random results against an arithmetic model,
// reset mid-accumulation, and a COUNT=1 instance.
module tb_stream_accumulator;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0, out_ready = 1'b0;
    logic [3:0] in_data = '0;
    logic       in_ready, out_valid, out_ovf;
    logic [3:0] out_sum;

    logic       in_valid1 = 1'b0, out_ready1 = 1'b0;
    logic [3:0] in_data1 = '0;
    logic       in_ready1, out_valid1, out_ovf1;
    logic [3:0] out_sum1;

    int tests = 0, fails = 0;

    always #5 clk = ~clk;

    stream_accumulator #(.SIZE(4), .COUNT(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_ovf(out_ovf));

    stream_accumulator #(.SIZE(4), .COUNT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_sum(out_sum1), .out_ovf(out_ovf1));

    typedef struct {
        logic [3:0][3:0] ops;
        int              gap;
        int              hold;
        logic [3:0]      sum;
        logic            ovf;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [3:0][3:0] mk(input int a, b, c, d);
        return {4'(d), 4'(c), 4'(b), 4'(a)};
    endfunction

    // Reference: the result is the plain integer total, wrapped or clamped to 4 bits.
    function automatic logic [4:0] model(input logic [3:0][3:0] ops);
        int total = 0;
        for (int i = 0; i < 4; i++) total += int'(ops[i]);
`ifdef STREAM_ACCUMULATOR_SATURATE_EN
        return {total > 15, (total > 15) ? 4'hf : 4'(total)};
`else
        return {total > 15, 4'(total)};
`endif
    endfunction

    task automatic wait_ready(input string nm);
        int w = 0;
        while (!in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk({nm, " in_ready"}, in_ready, 1);
    endtask

    // Called at a negedge; drives one accept and returns at the following negedge.
    task automatic send(input logic [3:0] op, input string nm);
        wait_ready(nm);
        in_valid = 1'b1;
        in_data  = op;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 4'($urandom);
    endtask

    task automatic run4(input string nm, input logic [3:0][3:0] ops, input int gap, input int hold,
                        input logic [3:0] esum, input logic eovf);
        for (int i = 0; i < 4; i++) begin
            send(ops[i], nm);
            if (i < 3) begin
                chk({nm, " early out_valid"}, out_valid, 0);
                chk({nm, " acc out_sum"}, out_sum, 0);
                for (int g = 0; g < gap; g++) begin
                    in_data = 4'($urandom);
                    @(negedge clk);
                    chk({nm, " gap out_valid"}, out_valid, 0);
                end
            end
        end
        chk({nm, " out_valid"}, out_valid, 1);
        chk({nm, " out_sum"}, out_sum, esum);
        chk({nm, " out_ovf"}, out_ovf, eovf);
        chk({nm, " hold in_ready"}, in_ready, 0);
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            in_data  = 4'($urandom);
            @(negedge clk);
            chk({nm, " stall sum"}, {out_valid, in_ready, out_ovf, out_sum}, {1'b1, 1'b0, eovf, esum});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk({nm, " release"}, {out_valid, in_ready, out_ovf, out_sum}, {1'b0, 1'b1, 1'b0, 4'h0});
    endtask

    vec_t vecs[7];

    initial begin
        vecs[0] = '{mk(1, 2, 3, 4), 0, 0, 4'd10, 1'b0};
`ifdef STREAM_ACCUMULATOR_SATURATE_EN
        vecs[1] = '{mk(15, 1, 0, 0), 0, 0, 4'd15, 1'b1};
        vecs[5] = '{mk(15, 15, 15, 15), 1, 1, 4'd15, 1'b1};
        vecs[6] = '{mk(8, 8, 0, 3), 0, 0, 4'd15, 1'b1};
`else
        vecs[1] = '{mk(15, 1, 0, 0), 0, 0, 4'd0, 1'b1};
        vecs[5] = '{mk(15, 15, 15, 15), 1, 1, 4'd12, 1'b1};
        vecs[6] = '{mk(8, 8, 0, 3), 0, 0, 4'd3, 1'b1};
`endif
        vecs[2] = '{mk(1, 2, 3, 4), 0, 5, 4'd10, 1'b0};
        vecs[3] = '{mk(2, 2, 2, 2), 3, 0, 4'd8, 1'b0};
        vecs[4] = '{mk(5, 5, 5, 0), 2, 2, 4'd15, 1'b0};

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset outs", {in_ready, out_valid, out_ovf, out_sum}, 0);
        chk("reset outs1", {in_ready1, out_valid1, out_ovf1, out_sum1}, 0);
        rst_n = 1'b1;
        #1 chk("pre-edge in_ready", in_ready, 0);
        @(posedge clk);
        @(negedge clk);
        chk("post-reset in_ready", in_ready, 1);

        foreach (vecs[k]) run4($sformatf("vec%0d", k), vecs[k].ops, vecs[k].gap, vecs[k].hold,
                               vecs[k].sum, vecs[k].ovf);

        // Reset in the middle of a result discards it
        send(4'd9, "rst");
        send(4'd9, "rst");
        rst_n = 1'b0;
        #1 chk("rst async outs", {in_ready, out_valid, out_ovf, out_sum}, 0);
        @(negedge clk);
        chk("rst held outs", {in_ready, out_valid, out_ovf, out_sum}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        run4("after rst", mk(1, 1, 1, 1), 0, 0, 4'd4, 1'b0);

        // Random results against the model
        for (int r = 0; r < 25; r++) begin
            logic [3:0][3:0] ops;
            logic [4:0]      e;
            ops = 16'($urandom);
            e   = model(ops);
            run4($sformatf("rand%0d", r), ops, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                 e[3:0], e[4]);
        end

        // COUNT=1 instance
        chk("c1 in_ready", in_ready1, 1);
        in_valid1 = 1'b1;
        in_data1  = 4'd7;
        @(posedge clk);
        @(negedge clk);
        in_valid1 = 1'b0;
        chk("c1 result", {out_valid1, in_ready1, out_ovf1, out_sum1}, {1'b1, 1'b0, 1'b0, 4'd7});
        out_ready1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready1 = 1'b0;
        chk("c1 release", {out_valid1, in_ready1, out_sum1}, {1'b0, 1'b1, 4'd0});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/stream_accumulator.md
STREAM_ACCUMULATOR -- requirements
Module: stream_accumulator

Interface
REQ-001 SHALL have parameter SIZE, default 4: operand and result width in bits.
REQ-002 SHALL have parameter COUNT, default 4: operands summed per result; legal range COUNT >= 1.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  upstream operand valid.
REQ-006 SHALL have port in_ready  output  1  block can accept an operand this cycle.
REQ-007 SHALL have port in_data  input  SIZE  operand.
REQ-008 SHALL have port out_valid  output  1  result available.
REQ-009 SHALL have port out_ready  input  1  downstream accepts the result.
REQ-010 SHALL have port out_sum  output  SIZE  accumulated result.
REQ-011 SHALL have port out_ovf  output  1  a carry-out occurred during this result's accumulation.

Function
REQ-012 SHALL implement states IDLE, ACC and HOLD.
REQ-013 SHALL define accept as in_valid && in_ready; SHALL ignore in_data on non-accept cycles.
REQ-014 SHALL drive in_ready = 1 in IDLE and ACC, and 0 in HOLD; there is no HOLD-to-accept bypass.
REQ-015 SHALL, on accept in IDLE: acc <= in_data, cnt <= 1, ovf <= 0; next state ACC, or HOLD if COUNT == 1.
REQ-016 SHALL, on accept in ACC: form the SIZE+1-bit sum acc + in_data, store the low SIZE bits in acc, set ovf sticky when bit SIZE = 1, and increment cnt.
REQ-017 SHALL move from ACC to HOLD on the accept that makes cnt equal COUNT.
REQ-018 SHALL hold state and contents in ACC on cycles without an accept; gaps in in_valid are unlimited.
REQ-019 SHALL assert out_valid only in HOLD, starting the cycle after the COUNT-th accept (latency 1 cycle).
REQ-020 SHALL drive out_sum = acc and out_ovf = ovf in HOLD, held stable while out_valid && !out_ready.
REQ-021 SHALL drive out_sum = 0 and out_ovf = 0 in IDLE and ACC.
REQ-022 SHALL, on out_valid && out_ready, return to IDLE next cycle and clear acc, cnt and ovf.
REQ-023 SHALL size cnt as clog2(COUNT+1) bits; cnt SHALL never exceed COUNT.

Reset
REQ-024 SHALL, while rst_n = 0 and immediately on its assertion, force: state IDLE, acc 0, cnt 0, ovf 0, in_ready 0, out_valid 0, out_sum 0, out_ovf 0.
REQ-025 SHALL, on reset mid-accumulation or in HOLD, discard the partial or pending result; the first accept after release starts a new result.
REQ-026 SHALL drive in_ready = 1 from the first rising edge after rst_n deasserts.

Configuration
REQ-027 SHALL support macro STREAM_ACCUMULATOR_SATURATE_EN.
REQ-028 SHALL, when the macro is defined, load all-ones into acc on any carry-out and keep it all-ones for the rest of the result; ovf is set as in REQ-016.
REQ-029 SHALL, when the macro is undefined, wrap acc modulo 2^SIZE (REQ-016 behaviour).

Verification (SIZE=4, COUNT=4 unless stated)
REQ-030 SHALL cover: accepts 1,2,3,4 back-to-back -> out_valid the next cycle, out_sum=10, out_ovf=0.
REQ-031 SHALL cover: accepts 15,1,0,0 -> without macro out_sum=0, out_ovf=1; with macro out_sum=15, out_ovf=1.
REQ-032 SHALL cover: result pending with out_ready low for 5 cycles -> out_sum/out_ovf stable, in_ready=0; out_ready=1 -> IDLE next cycle, in_ready=1.
REQ-033 SHALL cover: in_valid toggling with 3-cycle gaps, operands 2,2,2,2 -> out_sum=8, no out_valid before the 4th accept.
REQ-034 SHALL cover: rst_n pulsed low after 2 accepts -> all outputs 0; then 1,1,1,1 -> out_sum=4.
REQ-035 SHALL cover: COUNT=1, accept 7 -> out_valid next cycle, out_sum=7, out_ovf=0.
